// File: rtl/bcd_cnt_n_if.sv
// Control and data bundle for one chainable BCD counter stage.
// The master drives requests and the load value; the slave returns the count and status.
interface bcd_cnt_n_if #(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned W = 4 * DIGITS;

    logic         en;
    logic         high_rst;
    logic         tick;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic         co;
    logic         bo;
    logic         load_err;
    logic [W-1:0] cnt;

    modport master (
        output en, high_rst, tick, up_dn, load, load_val,
        input  co, bo, load_err, cnt
    );

    modport slave (
        input  en, high_rst, tick, up_dn, load, load_val,
        output co, bo, load_err, cnt
    );
endinterface

// File: rtl/bcd_cnt_n.sv
// N-digit BCD modulo-BASE up/down counter with range-checked parallel load.
// Carry and borrow are combinational so the next chained stage advances on the same edge.
module bcd_cnt_n #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned BASE    = 24,
    parameter int unsigned INITIAL = 16
) (
    input  logic        clk,
    input  logic        rst,
    bcd_cnt_n_if.slave  bus
);
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned LIMIT = 10 ** DIGITS;

    // Binary-to-BCD conversion of elaboration constants.
    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    if (DIGITS < 1 || DIGITS > 6 || BASE < 2 || BASE > LIMIT || INITIAL >= BASE) begin : g_param_err
        $error("bcd_cnt_n: illegal DIGITS/BASE/INITIAL combination");
    end

    localparam logic [W-1:0] MAX_BCD  = to_bcd(BASE - 1);
    localparam logic [W-1:0] INIT_BCD = to_bcd(INITIAL);

    logic [W-1:0] cnt_q, cnt_d;
    logic         load_err_q, load_err_d;
    logic [W-1:0] inc_c, dec_c;
    logic         nibbles_ok_c;
    logic         load_ok_c;
    logic         at_max_c, at_zero_c;
    logic         count_c;

    // Digit-wise ripple increment/decrement and load nibble validation.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] nib;
        inc_c        = '0;
        dec_c        = '0;
        nibbles_ok_c = 1'b1;
        carry        = 1'b1;
        borrow       = 1'b1;
        nib          = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = cnt_q[4*i +: 4];
            if (carry) begin
                if (nib == 4'd9) begin
                    inc_c[4*i +: 4] = 4'd0;
                end else begin
                    inc_c[4*i +: 4] = 4'(nib + 4'd1);
                    carry           = 1'b0;
                end
            end else begin
                inc_c[4*i +: 4] = nib;
            end
            if (borrow) begin
                if (nib == 4'd0) begin
                    dec_c[4*i +: 4] = 4'd9;
                end else begin
                    dec_c[4*i +: 4] = 4'(nib - 4'd1);
                    borrow          = 1'b0;
                end
            end else begin
                dec_c[4*i +: 4] = nib;
            end
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                nibbles_ok_c = 1'b0;
            end
        end
    end

    // Valid BCD words order the same as their numeric values, so compare directly.
    assign load_ok_c = nibbles_ok_c && (bus.load_val <= MAX_BCD);
    assign at_max_c  = (cnt_q == MAX_BCD);
    assign at_zero_c = (cnt_q == '0);
    assign count_c   = bus.en & bus.tick & ~rst & ~bus.high_rst & ~bus.load;

    // Next-state selection in priority order: high_rst > load > count > hold.
    always_comb begin
        cnt_d      = cnt_q;
        load_err_d = 1'b0;
        if (bus.high_rst) begin
            cnt_d = INIT_BCD;
        end else if (bus.load) begin
            if (load_ok_c) begin
                cnt_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (count_c) begin
            if (bus.up_dn) begin
                cnt_d = at_max_c ? '0 : inc_c;
            end else begin
                cnt_d = at_zero_c ? MAX_BCD : dec_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= INIT_BCD;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.load_err = load_err_q;
    assign bus.co       = count_c & bus.up_dn & at_max_c;
    assign bus.bo       = count_c & ~bus.up_dn & at_zero_c;
endmodule
